// File: rtl/cache_wbbuffer.sv
// cache_wbbuffer
// Multi-entry write-back (victim) buffer between the L1 cache and the bus
// write path. Dirty victim lines are accepted whole in one cycle and drained
// to the bus in FIFO order, one beat per BusBeatAck. A combinational lookup
// lets a refill of a still-buffered line forward the youngest buffered copy.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   EvictValid/EvictReady         victim handshake (EvictReady = ~Full)
//   EvictAdr, EvictLine           victim line address (offset ignored) / data
//   LookupAdr                     refill address to check (offset ignored)
//   LookupHit, LookupLine         match flag / youngest matching line
//   BusWriteReq                   head entry awaiting drain
//   BusAdr, BusBeatCount          head line address / current beat index
//   BusWriteData, BusLastBeat     current beat data / final beat flag
//   BusBeatAck                    bus accepted the current beat
//   Empty, Full                   occupancy flags
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | buffer empty, nothing to drain
// BEAT  | head entry draining, one beat per BusBeatAck

`ifndef PA_BITS
`define PA_BITS 32
`endif

module cache_wbbuffer #(
   parameter int LINELEN    = 512,
   parameter int BEATLEN    = 64,
   parameter int NUMENTRIES = 4,
   localparam int BEATS     = LINELEN / BEATLEN,
   localparam int LOGBEATS  = $clog2(BEATS),
   localparam int OFFSETLEN = $clog2(LINELEN / 8)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  EvictValid,
   output logic                  EvictReady,
   input  logic [`PA_BITS-1:0]   EvictAdr,
   input  logic [LINELEN-1:0]    EvictLine,
   input  logic [`PA_BITS-1:0]   LookupAdr,
   output logic                  LookupHit,
   output logic [LINELEN-1:0]    LookupLine,
   output logic                  BusWriteReq,
   output logic [`PA_BITS-1:0]   BusAdr,
   output logic [LOGBEATS-1:0]   BusBeatCount,
   output logic [BEATLEN-1:0]    BusWriteData,
   output logic                  BusLastBeat,
   input  logic                  BusBeatAck,
   output logic                  Empty,
   output logic                  Full
);

   localparam int PW   = $clog2(NUMENTRIES);
   localparam int CW   = PW + 1;
   localparam int TAGW = `PA_BITS - OFFSETLEN;

   typedef enum logic {S_IDLE, S_BEAT} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         head_q, head_d;
   logic [PW-1:0]         tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;
   logic [LOGBEATS-1:0]   beat_q, beat_d;
   logic [NUMENTRIES-1:0] valid_q, valid_d;
   logic [TAGW-1:0]       tag_q  [NUMENTRIES];
   logic [TAGW-1:0]       tag_d  [NUMENTRIES];
   logic [LINELEN-1:0]    line_q [NUMENTRIES];
   logic [LINELEN-1:0]    line_d [NUMENTRIES];

   logic                  push;
   logic                  pop;
   logic                  last_beat;
   logic [PW-1:0]         lookup_idx;
   logic                  unused_offset_bits;

   assign unused_offset_bits = ^{EvictAdr[OFFSETLEN-1:0], LookupAdr[OFFSETLEN-1:0]};

   // Readiness comes from the registered count, so a slot freed by a
   // last-beat ack only becomes usable on the following cycle.
   assign Full       = (count_q == CW'(NUMENTRIES));
   assign Empty      = (count_q == '0);
   assign EvictReady = ~Full;

   assign last_beat  = (beat_q == LOGBEATS'(BEATS - 1));
   assign push       = EvictValid & ~Full;
   assign pop        = (state_q == S_BEAT) & BusBeatAck & last_beat;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      line_d  = line_q;
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (push) begin
         valid_d[tail_q] = 1'b1;
         tag_d[tail_q]   = EvictAdr[`PA_BITS-1:OFFSETLEN];
         line_d[tail_q]  = EvictLine;
         tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      BusWriteReq = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_d != '0) state_d = S_BEAT;
         end
         S_BEAT: begin
            BusWriteReq = 1'b1;
            if (BusBeatAck) begin
               beat_d = pop ? '0 : beat_q + 1'b1;
               if (pop && count_d == '0) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign BusAdr       = {tag_q[head_q], OFFSETLEN'(0)};
   assign BusBeatCount = beat_q;
   assign BusWriteData = line_q[head_q][int'(beat_q) * BEATLEN +: BEATLEN];
   assign BusLastBeat  = BusWriteReq & last_beat;

   // Scan oldest to youngest so the last match seen is the youngest copy.
   always_comb begin
      LookupHit  = 1'b0;
      LookupLine = '0;
      lookup_idx = '0;
      for (int i = 0; i < NUMENTRIES; i++) begin
         lookup_idx = head_q + PW'(i);
         if (valid_q[lookup_idx] &&
             tag_q[lookup_idx] == LookupAdr[`PA_BITS-1:OFFSETLEN]) begin
            LookupHit  = 1'b1;
            LookupLine = line_q[lookup_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         beat_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         beat_q  <= beat_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      line_q <= line_d;
   end

endmodule
